// File: rtl/freq_poll_master.sv
// freq_poll_master: Avalon-MM master that arms the frequency-meter slave,
// confirms the arm by reading it back, and waits out a programmable gate time.
// It then reads the N and M counts and hands each pair to a consumer over a
// valid/ready result port.
module freq_poll_master #(
    parameter logic [31:0] GATE_CYCLES = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [1:0]  m_address,
    output logic        m_write,
    output logic [31:0] m_writedata,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    output logic [21:0] res_n,
    output logic [12:0] res_m,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        busy,
    output logic        arm_err
);

    typedef enum logic [2:0] {
        IDLE,
        WR_START,
        RD_CHK,
        GATE,
        RD_N,
        RD_M,
        PRESENT,
        WR_STOP
    } state_t;

    localparam logic [1:0]  ADDR_N    = 2'd0;
    localparam logic [1:0]  ADDR_M    = 2'd1;
    localparam logic [1:0]  ADDR_CTRL = 2'd2;
    localparam logic [31:0] GATE_LOAD = GATE_CYCLES - 32'd1;

    state_t      state_q;
    logic [31:0] gateCnt_q;
    logic [1:0]  mAddress_q;
    logic        mWrite_q;
    logic        mWriteBit_q;
    logic        mRead_q;
    logic [21:0] resN_q;
    logic [12:0] resM_q;
    logic        resValid_q;
    logic        busy_q;
    logic        armErr_q;

    // Only the low 22 bits of the read bus ever carry a count we keep.
    logic unusedReadBits;
    assign unusedReadBits = ^m_readdata[31:22];

    // Outputs come straight from registers so the bus sees glitch-free strobes.
    assign m_address   = mAddress_q;
    assign m_write     = mWrite_q;
    assign m_writedata = {31'd0, mWriteBit_q};
    assign m_read      = mRead_q;
    assign res_n       = resN_q;
    assign res_m       = resM_q;
    assign res_valid   = resValid_q;
    assign busy        = busy_q;
    assign arm_err     = armErr_q;

    // Measurement sequencer: every strobe/address change is made on the edge
    // that completes the previous transfer, so nothing moves during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gateCnt_q   <= 32'd0;
            mAddress_q  <= 2'd0;
            mWrite_q    <= 1'b0;
            mWriteBit_q <= 1'b0;
            mRead_q     <= 1'b0;
            resN_q      <= 22'd0;
            resM_q      <= 13'd0;
            resValid_q  <= 1'b0;
            busy_q      <= 1'b0;
            armErr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q     <= WR_START;
                        mWrite_q    <= 1'b1;
                        mAddress_q  <= ADDR_CTRL;
                        mWriteBit_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                WR_START: begin
                    if (!m_waitrequest) begin
                        state_q    <= RD_CHK;
                        mWrite_q   <= 1'b0;
                        mRead_q    <= 1'b1;
                        mAddress_q <= ADDR_CTRL;
                    end
                end
                RD_CHK: begin
                    if (!m_waitrequest) begin
                        mRead_q <= 1'b0;
                        if (m_readdata[0]) begin
                            state_q   <= GATE;
                            gateCnt_q <= GATE_LOAD;
                        end else begin
                            state_q     <= WR_START;
                            armErr_q    <= 1'b1;
                            mWrite_q    <= 1'b1;
                            mWriteBit_q <= 1'b1;
                        end
                    end
                end
                GATE: begin
                    if (!enable) begin
                        state_q     <= WR_STOP;
                        mWrite_q    <= 1'b1;
                        mAddress_q  <= ADDR_CTRL;
                        mWriteBit_q <= 1'b0;
                    end else if (gateCnt_q == 32'd0) begin
                        state_q    <= RD_N;
                        mRead_q    <= 1'b1;
                        mAddress_q <= ADDR_N;
                    end else begin
                        gateCnt_q <= gateCnt_q - 32'd1;
                    end
                end
                RD_N: begin
                    if (!m_waitrequest) begin
                        state_q    <= RD_M;
                        resN_q     <= m_readdata[21:0];
                        mAddress_q <= ADDR_M;
                    end
                end
                RD_M: begin
                    if (!m_waitrequest) begin
                        state_q    <= PRESENT;
                        resM_q     <= m_readdata[12:0];
                        mRead_q    <= 1'b0;
                        resValid_q <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (res_ready) begin
                        resValid_q <= 1'b0;
                        if (enable) begin
                            state_q   <= GATE;
                            gateCnt_q <= GATE_LOAD;
                        end else begin
                            state_q     <= WR_STOP;
                            mWrite_q    <= 1'b1;
                            mAddress_q  <= ADDR_CTRL;
                            mWriteBit_q <= 1'b0;
                        end
                    end
                end
                WR_STOP: begin
                    if (!m_waitrequest) begin
                        state_q  <= IDLE;
                        mWrite_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    mWrite_q <= 1'b0;
                    mRead_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_poll_master.sv
// tb_freq_poll_master: directed bench for freq_poll_master with a small
// Avalon slave model, a bus transfer log and a result scoreboard.
module tb_freq_poll_master;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [1:0]  m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_read;
    logic [31:0] m_readdata;
    logic        m_waitrequest;
    logic [21:0] res_n;
    logic [12:0] res_m;
    logic        res_valid;
    logic        res_ready;
    logic        busy;
    logic        arm_err;

    typedef struct {
        int         cyc;
        bit         wr;
        logic [1:0] addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        logic [21:0] n;
        logic [12:0] m;
        int          cyc;
    } res_t;

    xfer_t xferLog[$];
    res_t  expQ[$];

    int errCount = 0;
    int checkCount = 0;
    int edgeCnt = 0;
    int base = 0;

    int          stallCfg = 0;
    int          stallLeft = 0;
    bit          inXfer = 0;
    bit          startReg = 0;
    int          failsLeft = 0;
    logic [31:0] nVal = 32'd0;
    logic [31:0] mVal = 32'd0;
    bit          prevStall = 0;
    logic [35:0] prevBus = 36'd0;

    freq_poll_master #(.GATE_CYCLES(32'd4)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .m_address    (m_address),
        .m_write      (m_write),
        .m_writedata  (m_writedata),
        .m_read       (m_read),
        .m_readdata   (m_readdata),
        .m_waitrequest(m_waitrequest),
        .res_n        (res_n),
        .res_m        (res_m),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .busy         (busy),
        .arm_err      (arm_err)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: relative to base it names the cycle currently running.
    always @(posedge clk) edgeCnt++;

    // Safety net so a stuck run still ends with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] outVec();
        return {54'd0, m_address, m_write, m_writedata, m_read, res_n, res_m, res_valid, busy, arm_err};
    endfunction

    // Slave model and bus monitor: stalls each transfer stallCfg cycles,
    // answers reads, checks hold-during-stall, and logs completed transfers.
    always @(negedge clk) begin
        if (rst) begin
            m_waitrequest = 1'b0;
            m_readdata    = 32'd0;
            inXfer        = 1'b0;
            prevStall     = 1'b0;
        end else begin
            if (prevStall)
                checkOutput("stall_hold", {m_read, m_write, m_address, m_writedata}, prevBus);
            if (m_read || m_write) begin
                checkOutput("one_strobe", m_read & m_write, 0);
                if (!inXfer) begin
                    inXfer    = 1'b1;
                    stallLeft = stallCfg;
                end
                if (stallLeft > 0) begin
                    m_waitrequest = 1'b1;
                    m_readdata    = 32'hBAD0BAD0;
                    stallLeft--;
                end else begin
                    m_waitrequest = 1'b0;
                    inXfer        = 1'b0;
                    if (m_read) begin
                        case (m_address)
                            2'd0: m_readdata = nVal;
                            2'd1: m_readdata = mVal;
                            2'd2: begin
                                if (failsLeft > 0) begin
                                    m_readdata = 32'd0;
                                    failsLeft--;
                                end else begin
                                    m_readdata = {31'd0, startReg};
                                end
                            end
                            default: m_readdata = 32'd0;
                        endcase
                    end else if (m_address == 2'd2) begin
                        startReg = m_writedata[0];
                    end
                    xferLog.push_back('{cyc: edgeCnt, wr: m_write, addr: m_address,
                                       data: (m_write ? m_writedata : 32'd0)});
                end
            end else begin
                m_waitrequest = 1'b0;
                inXfer        = 1'b0;
            end
            prevStall = (m_read || m_write) && m_waitrequest;
            prevBus   = {m_read, m_write, m_address, m_writedata};
        end
    end

    // Scoreboard monitor: every accepted result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("sb_unexpected_result", 1, 0);
            end else begin
                res_t e;
                e = expQ.pop_front();
                checkOutput("sb_res_n", res_n, e.n);
                checkOutput("sb_res_m", res_m, e.m);
                checkOutput("sb_accept_cycle", edgeCnt, e.cyc);
            end
        end
    end

    // Land at the start (posedge + 2) of cycle n, or stay if already there.
    task automatic waitCycle(input int n);
        while (edgeCnt - base < n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Land on the negedge of cycle n.
    task automatic atNeg(input int n);
        do @(negedge clk); while (edgeCnt - base < n);
    endtask

    task automatic applyStimulus(input int n, input bit en, input bit rdy);
        waitCycle(n);
        enable    = en;
        res_ready = rdy;
    endtask

    task automatic applyReset();
        @(posedge clk);
        #2;
        rst       = 1'b1;
        enable    = 1'b0;
        res_ready = 1'b0;
        #1;
        checkOutput("reset_outputs", outVec(), 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Raise enable just before edge 0 of a new run; cycle 1 follows edge 0.
    task automatic startRun();
        @(posedge clk);
        #2;
        base = edgeCnt;
        xferLog.delete();
        enable = 1'b1;
    endtask

    task automatic checkXfer(input string name, input int idx, input int relCyc,
                             input bit wr, input logic [1:0] addr, input logic [31:0] data);
        if (idx >= xferLog.size()) begin
            checkOutput({name, "_present"}, xferLog.size(), idx + 1);
        end else begin
            checkOutput({name, "_cycle"}, xferLog[idx].cyc - base, relCyc);
            checkOutput({name, "_kind"}, {xferLog[idx].wr, xferLog[idx].addr, xferLog[idx].data},
                        {wr, addr, data});
        end
    endtask

    // Basic run, 10 cycles of back-pressure, then enable dropped mid-gate.
    task automatic testBasic();
        applyReset();
        stallCfg = 0; failsLeft = 0; startReg = 0;
        nVal = 32'hFFEFAF08;
        mVal = 32'hDEADE123;
        res_ready = 1'b0;
        startRun();
        expQ.push_back('{n: 22'h2FAF08, m: 13'h0123, cyc: base + 19});
        atNeg(2);
        checkOutput("basic_armerr_c2", arm_err, 0);
        atNeg(3);
        checkOutput("basic_gate_c3", {busy, m_read, m_write}, 3'b100);
        atNeg(9);
        checkOutput("basic_valid_c9", {res_valid, res_n, res_m}, {1'b1, 22'h2FAF08, 13'h0123});
        checkXfer("basic_wr_start", 0, 1, 1, 2'd2, 32'd1);
        checkXfer("basic_rd_chk", 1, 2, 0, 2'd2, 32'd0);
        checkXfer("basic_rd_n", 2, 7, 0, 2'd0, 32'd0);
        checkXfer("basic_rd_m", 3, 8, 0, 2'd1, 32'd0);
        for (int k = 10; k <= 18; k++) begin
            atNeg(k);
            checkOutput("bp_hold", {res_valid, res_n, res_m, m_read, m_write},
                        {1'b1, 22'h2FAF08, 13'h0123, 2'b00});
        end
        applyStimulus(19, 1'b1, 1'b1);
        atNeg(20);
        checkOutput("bp_gate_after_accept", {res_valid, busy, m_read, m_write}, 4'b0100);
        checkOutput("bp_no_bus", xferLog.size(), 4);
        applyStimulus(22, 1'b0, 1'b1);
        atNeg(23);
        checkOutput("abort_wr_stop", {m_write, m_address, m_writedata}, {1'b1, 2'd2, 32'd0});
        atNeg(24);
        checkOutput("abort_idle", {busy, m_write, res_valid}, 3'b000);
        checkXfer("abort_stop_xfer", 4, 23, 1, 2'd2, 32'd0);
        atNeg(30);
        checkOutput("abort_no_more", {xferLog.size(), res_valid}, {32'd5, 1'b0});
    endtask

    // Three wait states on every transfer.
    task automatic testStall();
        applyReset();
        stallCfg = 3; failsLeft = 0; startReg = 0;
        nVal = 32'h003FFFFF;
        mVal = 32'h00001FFF;
        res_ready = 1'b1;
        startRun();
        expQ.push_back('{n: 22'h3FFFFF, m: 13'h1FFF, cyc: base + 21});
        atNeg(2);
        checkOutput("stall_wr_held", {m_write, m_address, m_writedata, m_waitrequest},
                    {1'b1, 2'd2, 32'd1, 1'b1});
        applyStimulus(21, 1'b0, 1'b1);
        atNeg(26);
        checkOutput("stall_idle", busy, 0);
        checkXfer("stall_wr_start", 0, 4, 1, 2'd2, 32'd1);
        checkXfer("stall_rd_chk", 1, 8, 0, 2'd2, 32'd0);
        checkXfer("stall_rd_n", 2, 16, 0, 2'd0, 32'd0);
        checkXfer("stall_rd_m", 3, 20, 0, 2'd1, 32'd0);
        checkXfer("stall_wr_stop", 4, 25, 1, 2'd2, 32'd0);
        stallCfg = 0;
    endtask

    // Start readback fails twice before the arm sticks; M = 0 passes through.
    task automatic testArmRetry();
        applyReset();
        stallCfg = 0; failsLeft = 2; startReg = 0;
        nVal = 32'h00123456;
        mVal = 32'hFFFFE000;
        res_ready = 1'b1;
        startRun();
        expQ.push_back('{n: 22'h123456, m: 13'h0000, cyc: base + 13});
        atNeg(2);
        checkOutput("arm_err_before", arm_err, 0);
        atNeg(3);
        checkOutput("arm_err_after", {arm_err, m_write}, 2'b11);
        applyStimulus(13, 1'b0, 1'b1);
        atNeg(15);
        checkOutput("retry_idle_sticky", {busy, arm_err}, 2'b01);
        checkXfer("retry_wr1", 0, 1, 1, 2'd2, 32'd1);
        checkXfer("retry_rd1", 1, 2, 0, 2'd2, 32'd0);
        checkXfer("retry_wr2", 2, 3, 1, 2'd2, 32'd1);
        checkXfer("retry_rd2", 3, 4, 0, 2'd2, 32'd0);
        checkXfer("retry_wr3", 4, 5, 1, 2'd2, 32'd1);
        checkXfer("retry_rd3", 5, 6, 0, 2'd2, 32'd0);
        checkXfer("retry_rd_n", 6, 11, 0, 2'd0, 32'd0);
        checkXfer("retry_rd_m", 7, 12, 0, 2'd1, 32'd0);
        checkXfer("retry_wr_stop", 8, 14, 1, 2'd2, 32'd0);
    endtask

    // Reset lands while the N read is on the bus; the run restarts cleanly.
    task automatic testResetMid();
        applyReset();
        stallCfg = 0; failsLeft = 0; startReg = 0;
        nVal = 32'hFFEFAF08;
        mVal = 32'hDEADE123;
        res_ready = 1'b1;
        startRun();
        atNeg(7);
        checkOutput("rd_n_active", {m_read, m_address}, {1'b1, 2'd0});
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_outputs", outVec(), 0);
        @(posedge clk);
        #2;
        rst  = 1'b0;
        base = edgeCnt;
        xferLog.delete();
        expQ.push_back('{n: 22'h2FAF08, m: 13'h0123, cyc: base + 9});
        applyStimulus(9, 1'b0, 1'b1);
        atNeg(11);
        checkOutput("restart_idle", busy, 0);
        checkXfer("restart_wr_start", 0, 1, 1, 2'd2, 32'd1);
        checkXfer("restart_rd_chk", 1, 2, 0, 2'd2, 32'd0);
        checkXfer("restart_rd_n", 2, 7, 0, 2'd0, 32'd0);
        checkXfer("restart_rd_m", 3, 8, 0, 2'd1, 32'd0);
        checkXfer("restart_wr_stop", 4, 10, 1, 2'd2, 32'd0);
    endtask

    // Test sequence.
    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        res_ready = 1'b0;
        testBasic();
        testStall();
        testArmRetry();
        testResetMid();
        @(negedge clk);
        checkOutput("sb_drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/freq_poll_master.md
# freq_poll_master

Avalon-MM master that drives the frequency-meter register slave from the initiator side. It arms the meter by writing the start bit, verifies the arm by readback, and waits a programmable gate time. It then reads the N (reference count) and M (input count) registers and presents each measurement as a result beat on a valid/ready interface. It sits between the frequency-meter slave and any consumer that lacks a CPU, such as a display or logging path.

## Interface
- GATE_CYCLES, 50_000_000: gate time in clk cycles between arm-verify and reading N; legal range 1..2^32-1.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  level; 1 = run measurements continuously, 0 = stop after the current result.
- m_address  output  2  word address: 0 = N, 1 = M, 2 = start/control.
- m_write  output  1  Avalon write strobe.
- m_writedata  output  32  write data; only bit 0 is meaningful.
- m_read  output  1  Avalon read strobe.
- m_readdata  input  32  read data; valid on the cycle the read completes.
- m_waitrequest  input  1  slave stall; tie 0 for a zero-wait slave.
- res_n  output  22  captured N = m_readdata[21:0] from address 0.
- res_m  output  13  captured M = m_readdata[12:0] from address 1.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- busy  output  1  1 in every state except IDLE.
- arm_err  output  1  sticky; set when start readback returns bit0 = 0. Cleared only by rst.

## Operation
- States: IDLE, WR_START, RD_CHK, GATE, RD_N, RD_M, PRESENT, WR_STOP.
- IDLE: if enable = 1, go to WR_START.
- WR_START: m_write = 1, m_address = 2, m_writedata = 1. Completes to RD_CHK.
- RD_CHK: m_read = 1, m_address = 2.
  - On completion, if m_readdata[0] = 1, go to GATE.
  - Otherwise set arm_err and return to WR_START. Retries are unlimited.
- GATE: gate counter loads GATE_CYCLES-1 on entry and decrements each cycle. At 0, go to RD_N. GATE lasts exactly GATE_CYCLES cycles.
  - If enable = 0 during GATE, abort to WR_STOP on the next cycle. No result is produced.
- RD_N: read address 0. On completion, capture res_n and go to RD_M.
- RD_M: read address 1. On completion, capture res_m and go to PRESENT.
- PRESENT: res_valid = 1, with res_n and res_m held stable.
  - On res_valid & res_ready: if enable = 1, go to GATE (the meter stays armed, no re-arm); else go to WR_STOP.
- WR_STOP: write 0 to address 2, then go to IDLE.
- Bus rules:
  - At most one of m_read or m_write is high in any cycle.
  - Address, data, and strobe are held stable while m_waitrequest = 1.
  - A transfer completes on the first cycle with the strobe high and m_waitrequest = 0. Read data is sampled in that cycle.
  - Strobes are low in IDLE, GATE, and PRESENT.
- N and M are read in two separate transfers, so the pair is not atomic. The consumer tolerates this skew.
- M = 0 is passed through unchanged. Division and zero handling belong to the consumer.
- Reset values: all outputs 0; state IDLE; gate counter 0. Reset mid-transfer drops the strobes asynchronously. The slave is left armed, and the next arm rewrites start = 1.

## Timing
- All outputs are registered.
- With m_waitrequest tied 0 and enable rising before edge 0:
  - Cycle 1: WR_START write.
  - Cycle 2: RD_CHK read.
  - Cycles 3..2+G: GATE.
  - Cycle 3+G: RD_N.
  - Cycle 4+G: RD_M.
  - Cycle 5+G: res_valid = 1.
- Each wait-state cycle extends its own state by one cycle.
- Continuous mode with res_ready held 1: the result period is G+3 cycles (GATE + RD_N + RD_M + PRESENT).
- res_valid stays high until accepted. The back-pressure cycles are inserted before the next gate.
- arm_err asserts on the cycle after the failing RD_CHK completion.

## Test plan
- GATE_CYCLES = 4, waitrequest = 0, slave returns N = 0x2FAF08 masked to 22 bits and M = 0x0123; enable pulse held -> write addr 2 data 1 at cycle 1, read addr 2 at cycle 2, reads at cycles 7 and 8, res_valid at cycle 9 with res_n = 0x2FAF08 & 0x3FFFFF and res_m = 0x0123.
- Same setup with m_waitrequest high for 3 cycles on every transfer -> strobe, address, and data stable through the stalls; each state lengthened by 3 cycles; captured values unchanged.
- Start readback returns 0 twice, then 1 -> arm_err = 1 from the first failure onward, three WR_START writes seen, measurement then proceeds normally.
- res_ready held 0 for 10 cycles after res_valid -> res_valid and res_n/res_m stable for those 10 cycles; no bus activity; GATE begins the cycle after acceptance.
- enable dropped in the middle of GATE -> next cycle write addr 2 data 0, then IDLE with busy = 0; res_valid never asserted.
- rst asserted while m_read is high in RD_N -> all outputs 0 immediately; after release with enable = 1, the sequence restarts at WR_START.
